// File: rtl/fp_int_acc_pkg.sv
// Shared constants for the fp16 x int product accumulator: fp16 field layout,
// fixed-point mantissa format and default-width saturation bounds.
package fp_int_acc_pkg;

    localparam int EXP_W      = 5;
    localparam int MAN_W      = 10;
    localparam int FP16_BIAS  = 15;

    // Product magnitude from the serial multiplier: unsigned 4.10 fixed point.
    localparam int MANT_FIX_W = 14;
    localparam int MANT_FRAC  = 10;

    // Exponent value reserved for inf/NaN.
    localparam logic [EXP_W-1:0] EXP_INF = '1;

    // Saturation bounds for the default 32-bit accumulator.
    localparam logic signed [31:0] ACC_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] ACC_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fp_int_acc_if.sv
// Product input / partial-sum output bundle between the multiplier,
// the accumulator and the downstream consumer.
interface fp_int_acc_if
    import fp_int_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int LEN_W     = 8
);
    logic                        sign_in;
    logic [EXP_W-1:0]            exp_in;
    logic [MANT_FIX_W-1:0]       mantissa_in;
    logic                        start_acc;
    logic                        clear;
    logic [LEN_W-1:0]            acc_len;
    logic signed [ACC_WIDTH-1:0] acc_out;
    logic                        out_valid;
    logic                        ovf;
    logic [LEN_W-1:0]            term_cnt;

    modport master (
        output sign_in, exp_in, mantissa_in, start_acc, clear, acc_len,
        input  acc_out, out_valid, ovf, term_cnt
    );

    modport slave (
        input  sign_in, exp_in, mantissa_in, start_acc, clear, acc_len,
        output acc_out, out_valid, ovf, term_cnt
    );
endinterface

// File: rtl/fp_int_acc_align.sv
// Combinational exponent alignment: turns a sign / fp16 exponent / 4.10
// magnitude triple into a signed fixed-point term of the accumulator width.
module fp_int_align
    import fp_int_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int SHR       = 16
) (
    input  logic                        sign_i,
    input  logic [EXP_W-1:0]            exp_i,
    input  logic [MANT_FIX_W-1:0]       mant_i,
    output logic signed [ACC_WIDTH-1:0] term_o,
    output logic                        inf_o
);
    // Wide enough to hold the mantissa shifted by the largest exponent.
    localparam int SH_W = MANT_FIX_W + (1 << EXP_W) - 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [SH_W-1:0]      shifted;
    logic [SH_W-1:0]      mag;
    logic [ACC_WIDTH-1:0] mag_fit;

    // Align, drop SHR fraction bits (truncate toward zero), apply sign.
    always_comb begin
        shifted = {{(SH_W-MANT_FIX_W){1'b0}}, mant_i} << exp_i;
        mag     = shifted >> SHR;
        // Magnitudes that cannot be represented clamp to +max; never hit
        // for the default 32-bit / SHR=16 configuration.
        mag_fit = (|mag[SH_W-1:ACC_WIDTH-1]) ? SAT_MAX : mag[ACC_WIDTH-1:0];
        inf_o   = (exp_i == EXP_INF);
        if (inf_o)
            term_o = sign_i ? SAT_MIN : SAT_MAX;
        else
            term_o = sign_i ? -$signed(mag_fit) : $signed(mag_fit);
    end
endmodule

// File: rtl/fp_int_acc.sv
// Two-stage accumulator: S1 registers the aligned product, S2 performs a
// saturating add into the running group sum and publishes it on group close.
module fp_int_acc
    import fp_int_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int SHR       = 16,
    parameter int LEN_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    fp_int_acc_if.slave   bus
);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] al_term;
    logic                        al_inf;

    logic                        s1_valid_q, s1_valid_d;
    logic signed [ACC_WIDTH-1:0] s1_term_q,  s1_term_d;
    logic                        s1_inf_q,   s1_inf_d;

    logic signed [ACC_WIDTH-1:0] acc_q,      acc_d;
    logic [LEN_W-1:0]            cnt_q,      cnt_d;
    logic [LEN_W-1:0]            len_q,      len_d;
    logic                        ovf_q,      ovf_d;
    logic signed [ACC_WIDTH-1:0] acc_out_q,  acc_out_d;
    logic                        out_vld_q,  out_vld_d;

    logic                        first;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH:0]   wide;
    logic                        add_ovf;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [LEN_W-1:0]            len_eff;
    logic [LEN_W-1:0]            cnt_inc;
    logic                        grp_ovf;
    logic                        close;

    fp_int_align #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHR       (SHR)
    ) u_align (
        .sign_i (bus.sign_in),
        .exp_i  (bus.exp_in),
        .mant_i (bus.mantissa_in),
        .term_o (al_term),
        .inf_o  (al_inf)
    );

    // S1: capture the aligned term; clear in the same cycle drops it.
    always_comb begin
        s1_valid_d = bus.start_acc & ~bus.clear;
        s1_term_d  = s1_term_q;
        s1_inf_d   = s1_inf_q;
        if (bus.start_acc) begin
            s1_term_d = al_term;
            s1_inf_d  = al_inf;
        end
    end

    // S2: saturating accumulate, group-length bookkeeping and result publish.
    always_comb begin
        first   = (cnt_q == '0);
        base    = first ? '0 : acc_q;
        wide    = {base[ACC_WIDTH-1], base} + {s1_term_q[ACC_WIDTH-1], s1_term_q};
        add_ovf = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        sum     = add_ovf ? (wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX) : wide[ACC_WIDTH-1:0];
        // Group length is latched with the first term so mid-group changes wait.
        len_eff = first ? ((bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len) : len_q;
        cnt_inc = cnt_q + LEN_W'(1);
        grp_ovf = (~first & ovf_q) | add_ovf | s1_inf_q;
        close   = (cnt_inc == len_eff);

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        // ovf stays visible alongside the published result for one cycle.
        ovf_d     = out_vld_q ? 1'b0 : ovf_q;
        acc_out_d = acc_out_q;
        out_vld_d = 1'b0;

        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (s1_valid_q) begin
            acc_d = sum;
            len_d = len_eff;
            ovf_d = grp_ovf;
            if (close) begin
                acc_out_d = sum;
                out_vld_d = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d     = cnt_inc;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_term_q  <= '0;
            s1_inf_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            acc_out_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_term_q  <= s1_term_d;
            s1_inf_q   <= s1_inf_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            acc_out_q  <= acc_out_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign bus.acc_out   = acc_out_q;
    assign bus.out_valid = out_vld_q;
    assign bus.ovf       = ovf_q;
    assign bus.term_cnt  = cnt_q;
endmodule

// File: tb/tb_fp_int_acc.sv
// Self-checking bench for fp_int_acc: directed scenarios plus a randomized
// run, all compared against a longint reference model of the accumulator.
module tb_fp_int_acc;
    localparam int     W    = 32;
    localparam int     LW   = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_int_acc_if #(.ACC_WIDTH(W), .LEN_W(LW)) bus();

    fp_int_acc #(.ACC_WIDTH(W), .SHR(16), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_pv, m_pinf, m_gov, m_vld, m_ovf;
    longint      m_pt, m_sum;
    int          m_cnt, m_len;
    logic [31:0] m_acc_out;

    // Term value from the product's real value: mant * 2^exp / 2^16, toward zero.
    function automatic longint ref_term(bit s, int e, int m);
        longint mag;
        if (e == 31) return s ? MINV : MAXV;
        mag = (longint'(m) * (longint'(1) << e)) / 65536;
        return s ? -mag : mag;
    endfunction

    task automatic model_step(bit st, bit s, int e, int m, bit clr, int len, bit rn);
        bit     was_vld, of;
        longint t;
        if (!rn) begin
            m_pv = 0; m_pt = 0; m_pinf = 0; m_sum = 0; m_cnt = 0; m_len = 0;
            m_gov = 0; m_acc_out = '0; m_vld = 0; m_ovf = 0;
            return;
        end
        was_vld = m_vld;
        m_vld   = 0;
        if (was_vld) m_ovf = 0;
        if (clr) begin
            m_sum = 0; m_cnt = 0; m_gov = 0; m_ovf = 0;
        end else if (m_pv) begin
            if (m_cnt == 0) begin
                m_sum = 0; m_gov = 0; m_len = (len == 0) ? 1 : len;
            end
            t  = m_sum + m_pt;
            of = 0;
            if (t > MAXV) begin t = MAXV; of = 1; end
            else if (t < MINV) begin t = MINV; of = 1; end
            m_sum = t;
            m_gov = m_gov | of | m_pinf;
            m_ovf = m_gov;
            m_cnt++;
            if (m_cnt == m_len) begin
                m_acc_out = m_sum[31:0];
                m_vld     = 1;
                m_cnt     = 0;
            end
        end
        m_pv   = st && !clr;
        m_pt   = ref_term(s, e, m);
        m_pinf = (e == 31);
    endtask

    function automatic logic [41:0] expv();
        return {m_vld, m_ovf, m_cnt[7:0], m_acc_out};
    endfunction

    function automatic logic [41:0] obsv();
        return {bus.out_valid, bus.ovf, bus.term_cnt, bus.acc_out};
    endfunction

    // One clock: drive at negedge, step the model at posedge, settle.
    task automatic tick(bit st, bit s, int e, int m, bit clr, int len, bit rn);
        @(negedge clk);
        rst             = rn;
        bus.start_acc   = st;
        bus.sign_in     = s;
        bus.exp_in      = 5'(e);
        bus.mantissa_in = 14'(m);
        bus.clear       = clr;
        bus.acc_len     = 8'(len);
        @(posedge clk);
        model_step(st, s, e, m, clr, len, rn);
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if (obsv() !== 42'd0) begin
            n_err++;
            $display("FAIL reset: got %h want 0", obsv());
        end
        tick(0, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if (obsv() !== expv()) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_single();
        tick(1, 0, 15, 1024, 0, 1, 1);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: out_valid %b want 0", bus.out_valid);
        end
        tick(0, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.acc_out !== 32'd512 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL single: vld=%b acc=%0d ovf=%b want 1/512/0", bus.out_valid, bus.acc_out, bus.ovf);
        end
        tick(0, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if (obsv() !== expv() || bus.out_valid !== 1'b0 || bus.acc_out !== 32'd512) begin
            n_err++;
            $display("FAIL single_after: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_group3();
        int nv = 0;
        logic [31:0] got = '0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: tick(1, 0, 15, 4608, 0, 3, 1);
                1: tick(1, 1, 15, 4608, 0, 3, 1);
                2: tick(1, 0, 16, 1024, 0, 3, 1);
                default: tick(0, 0, 0, 0, 0, 3, 1);
            endcase
            if (bus.out_valid === 1'b1) begin nv++; got = bus.acc_out; end
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL group3_cyc%0d: got %h want %h", i, obsv(), expv());
            end
        end
        n_vec++;
        if (nv != 1 || got !== 32'd1024 || bus.term_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL group3: valids=%0d acc=%0d cnt=%0d want 1/1024/0", nv, got, bus.term_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick(i < 6, 0, 15, 1024, 0, 2, 1);
            if (bus.out_valid === 1'b1) begin
                nv++;
                if (bus.acc_out !== 32'd1024) bad++;
            end
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL b2b_cyc%0d: got %h want %h", i, obsv(), expv());
            end
        end
        n_vec++;
        if (nv != 3 || bad != 0) begin
            n_err++;
            $display("FAIL b2b: valids=%0d bad_sums=%0d want 3/0", nv, bad);
        end
    endtask

    task automatic test_saturation();
        int seen = 0;
        // 8 of these sum to just under 2^31; the 9th crosses it.
        for (int i = 0; i < 11; i++) begin
            tick(i < 9, 0, 30, 16383, 0, 9, 1);
            if (bus.out_valid === 1'b1) begin
                seen++;
                n_vec++;
                if (bus.acc_out !== 32'h7FFF_FFFF || bus.ovf !== 1'b1) begin
                    n_err++;
                    $display("FAIL sat: acc=%h ovf=%b want 7fffffff/1", bus.acc_out, bus.ovf);
                end
            end else if (seen == 1) begin
                seen++;
                n_vec++;
                if (bus.ovf !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_ovf_clr: ovf=%b want 0", bus.ovf);
                end
            end
        end
        // +inf term followed by +1.0 stays pinned at +max with ovf.
        tick(1, 0, 31, 0, 0, 2, 1);
        tick(1, 0, 15, 1024, 0, 2, 1);
        tick(0, 0, 0, 0, 0, 2, 1);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.acc_out !== 32'h7FFF_FFFF || bus.ovf !== 1'b1 || seen != 2) begin
            n_err++;
            $display("FAIL inf: vld=%b acc=%h ovf=%b seen=%0d want 1/7fffffff/1/2",
                     bus.out_valid, bus.acc_out, bus.ovf, seen);
        end
        tick(0, 0, 0, 0, 0, 2, 1);
    endtask

    task automatic test_clear();
        int nv = 0;
        logic [31:0] got = '0;
        tick(1, 0, 15, 1024, 0, 3, 1);
        tick(1, 0, 15, 1024, 1, 3, 1);
        n_vec++;
        if (bus.term_cnt !== 8'd0 || bus.out_valid !== 1'b0 || obsv() !== expv()) begin
            n_err++;
            $display("FAIL clear: cnt=%0d vld=%b want 0/0", bus.term_cnt, bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick(i < 3, 0, 15, 1024, 0, 3, 1);
            if (bus.out_valid === 1'b1) begin nv++; got = bus.acc_out; end
        end
        n_vec++;
        if (nv != 1 || got !== 32'd1536) begin
            n_err++;
            $display("FAIL clear_regroup: valids=%0d acc=%0d want 1/1536", nv, got);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        logic [31:0] got = '0;
        tick(1, 0, 15, 1024, 0, 4, 1);
        tick(1, 0, 15, 1024, 0, 4, 1);
        tick(0, 0, 0, 0, 0, 4, 1);
        n_vec++;
        if (bus.term_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL rst_mid_pre: cnt=%0d want 2", bus.term_cnt);
        end
        tick(0, 0, 0, 0, 0, 4, 0);
        n_vec++;
        if (obsv() !== 42'd0) begin
            n_err++;
            $display("FAIL rst_mid: got %h want 0", obsv());
        end
        for (int i = 0; i < 6; i++) begin
            tick(i < 4, 0, 15, 1024, 0, 4, 1);
            if (bus.out_valid === 1'b1) begin nv++; got = bus.acc_out; end
        end
        n_vec++;
        if (nv != 1 || got !== 32'd2048) begin
            n_err++;
            $display("FAIL rst_mid_regroup: valids=%0d acc=%0d want 1/2048", nv, got);
        end
    endtask

    task automatic test_random();
        int len = 3;
        for (int i = 0; i < 600; i++) begin
            int  r, e, m;
            bit  st, s, clr, rn;
            st = ($urandom % 10) < 7;
            r  = $urandom % 16;
            if (r == 0)      e = 31;
            else if (r == 1) e = 0;
            else             e = $urandom_range(8, 22);
            s   = (e == 31) ? 1'b0 : 1'($urandom % 2);
            m   = $urandom % 16384;
            clr = ($urandom % 40) == 0;
            rn  = ($urandom % 150) != 0;
            if (($urandom % 30) == 0) len = $urandom % 6;
            tick(st, s, e, m, clr, len, rn);
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL random_cyc%0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        bus.start_acc   = 1'b0;
        bus.sign_in     = 1'b0;
        bus.exp_in      = '0;
        bus.mantissa_in = '0;
        bus.clear       = 1'b0;
        bus.acc_len     = 8'd1;
        model_step(0, 0, 0, 0, 0, 1, 0);
        test_reset();
        test_single();
        test_group3();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
